// File: rtl/i2c_ctrl_pkg.sv
// Shared definitions for the control-bus I2C master, the control slave and the bench:
// FSM encodings, quarter phases, default slave address and control register indices.
package i2c_ctrl_pkg;

   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_START = 3'd1,
      ST_BYTE  = 3'd2,
      ST_ACK   = 3'd3,
      ST_STOP  = 3'd4
   } i2c_state_t;

   localparam logic [1:0] Q0 = 2'd0;
   localparam logic [1:0] Q1 = 2'd1;
   localparam logic [1:0] Q2 = 2'd2;
   localparam logic [1:0] Q3 = 2'd3;

   localparam logic [6:0] DEFAULT_SLAVE_ADDR = 7'h10;

   localparam logic [7:0] REG_RX_FREQ  = 8'h00;
   localparam logic [7:0] REG_TX_FREQ  = 8'h01;
   localparam logic [7:0] REG_S_RATE   = 8'h02;
   localparam logic [7:0] REG_TX_LEVEL = 8'h03;

   localparam logic [2:0] MAX_PAYLOAD = 3'd4;

   function automatic logic [2:0] clamp_nbytes(input logic [2:0] n);
      return (n > MAX_PAYLOAD) ? MAX_PAYLOAD : n;
   endfunction

endpackage

// File: rtl/i2c_qtick_gen.sv
// Quarter-bit tick generator: one tick every CLK_DIV cycles while enabled; cleared when
// disabled. hold parks the counter on its last count so a stretched SCL delays the tick.
module i2c_qtick_gen #(
   parameter int CLK_DIV = 5
)(
   input  logic clk,
   input  logic reset,
   input  logic en,
   input  logic hold,
   output logic tick
);

   localparam int CW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
   localparam logic [CW-1:0] LAST = CW'(CLK_DIV - 1);

   logic [CW-1:0] cnt;

   assign tick = en && !hold && (cnt == LAST);

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         cnt <= '0;
      end else if (!en) begin
         cnt <= '0;
      end else if (cnt == LAST) begin
         if (!hold)
            cnt <= '0;
      end else begin
         cnt <= cnt + CW'(1);
      end
   end

endmodule

// File: rtl/i2c_ctrl_master.sv
// Write-only I2C master for the control register block: START, addr+W, register index,
// 0..4 payload bytes, STOP. Clock stretching with timeout when I2C_STRETCH_EN is defined.
//
// state    | meaning
// ST_IDLE  | bus released, waiting for start
// ST_START | START condition, 4 quarters
// ST_BYTE  | 8 data bits, MSB first, 4 quarters each
// ST_ACK   | SDA released, slave ACK sampled at end of q2
// ST_STOP  | STOP condition, then done pulse
module i2c_ctrl_master
   import i2c_ctrl_pkg::*;
#(
   parameter int         CLK_DIV    = 5,
   parameter logic [6:0] SLAVE_ADDR = DEFAULT_SLAVE_ADDR,
   parameter int         STRETCH_TO = 1023
)(
   input  logic        clk,
   input  logic        reset,
   input  logic        start,
   input  logic [7:0]  reg_addr,
   input  logic [31:0] wdata,
   input  logic [2:0]  nbytes,
   output logic        busy,
   output logic        done,
   output logic        ack_err,
   output logic        scl_oe,
   output logic        sda_oe,
   input  logic        scl_in,
   input  logic        sda_in
);

   i2c_state_t  state;
   logic [1:0]  q;
   logic [2:0]  bit_cnt;
   logic [2:0]  bytes_left;
   logic [47:0] data_sr;
   logic        nack;
   logic        scl_meta, scl_s, sda_meta, sda_s;
   logic        tick, hold, timeout;

   // Bus idles high, so the synchronisers reset to 1.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         scl_meta <= 1'b1;
         scl_s    <= 1'b1;
         sda_meta <= 1'b1;
         sda_s    <= 1'b1;
      end else begin
         scl_meta <= scl_in;
         scl_s    <= scl_meta;
         sda_meta <= sda_in;
         sda_s    <= sda_meta;
      end
   end

`ifdef I2C_STRETCH_EN
   logic [15:0] stretch_cnt;

   // Only gates the quarter tick, so the synchroniser delay after our own release is hidden.
   assign hold    = busy && !scl_oe && !scl_s;
   assign timeout = (stretch_cnt >= 16'(STRETCH_TO));

   always_ff @(posedge clk or posedge reset) begin
      if (reset)
         stretch_cnt <= '0;
      else if (busy && !scl_oe && !scl_s)
         stretch_cnt <= stretch_cnt + 16'd1;
      else
         stretch_cnt <= '0;
   end
`else
   logic unused_stretch;
   assign unused_stretch = &{1'b0, scl_s, (STRETCH_TO > 0)};
   assign hold    = 1'b0;
   assign timeout = 1'b0;
`endif

   i2c_qtick_gen #(.CLK_DIV(CLK_DIV)) u_qtick (
      .clk   (clk),
      .reset (reset),
      .en    (busy),
      .hold  (hold),
      .tick  (tick)
   );

   // On each tick q names the quarter that is ending; outputs are set for the next one.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state      <= ST_IDLE;
         q          <= Q0;
         bit_cnt    <= '0;
         bytes_left <= '0;
         data_sr    <= '0;
         nack       <= 1'b0;
         busy       <= 1'b0;
         done       <= 1'b0;
         ack_err    <= 1'b0;
         scl_oe     <= 1'b0;
         sda_oe     <= 1'b0;
      end else begin
         done <= 1'b0;
         if (state == ST_IDLE) begin
            if (start) begin
               state      <= ST_START;
               q          <= Q0;
               busy       <= 1'b1;
               ack_err    <= 1'b0;
               nack       <= 1'b0;
               bit_cnt    <= 3'd7;
               data_sr    <= {SLAVE_ADDR, 1'b0, reg_addr, wdata};
               bytes_left <= 3'd1 + clamp_nbytes(nbytes);
            end
         end else if (timeout) begin
            state   <= ST_IDLE;
            q       <= Q0;
            busy    <= 1'b0;
            done    <= 1'b1;
            ack_err <= 1'b1;
            scl_oe  <= 1'b0;
            sda_oe  <= 1'b0;
         end else if (tick) begin
            q <= q + 2'd1;
            unique case (state)
               ST_START: begin
                  case (q)
                     Q0: sda_oe <= 1'b1;
                     Q2: scl_oe <= 1'b1;
                     Q3: begin
                        state   <= ST_BYTE;
                        bit_cnt <= 3'd7;
                        sda_oe  <= ~data_sr[47];
                     end
                     default: ;
                  endcase
               end
               ST_BYTE: begin
                  case (q)
                     Q0: scl_oe <= 1'b0;
                     Q2: scl_oe <= 1'b1;
                     Q3: begin
                        data_sr <= {data_sr[46:0], 1'b0};
                        if (bit_cnt == 3'd0) begin
                           state  <= ST_ACK;
                           sda_oe <= 1'b0;
                        end else begin
                           bit_cnt <= bit_cnt - 3'd1;
                           sda_oe  <= ~data_sr[46];
                        end
                     end
                     default: ;
                  endcase
               end
               ST_ACK: begin
                  case (q)
                     Q0: scl_oe <= 1'b0;
                     Q2: begin
                        scl_oe <= 1'b1;
                        nack   <= sda_s;
                     end
                     Q3: begin
                        if (nack || bytes_left == 3'd0) begin
                           state  <= ST_STOP;
                           sda_oe <= 1'b1;
                        end else begin
                           state      <= ST_BYTE;
                           bytes_left <= bytes_left - 3'd1;
                           bit_cnt    <= 3'd7;
                           sda_oe     <= ~data_sr[47];
                        end
                     end
                     default: ;
                  endcase
               end
               ST_STOP: begin
                  case (q)
                     Q0: scl_oe <= 1'b0;
                     Q2: sda_oe <= 1'b0;
                     Q3: begin
                        state   <= ST_IDLE;
                        busy    <= 1'b0;
                        done    <= 1'b1;
                        ack_err <= nack;
                     end
                     default: ;
                  endcase
               end
               default: ;
            endcase
         end
      end
   end

endmodule
